// File: rtl/sram_port_arbiter.sv
// Two-requester round-robin arbiter for the 64-bit calculator memory: independent
// write-port and read-port FSMs with bounded locks and read/write collision blocking.

module sram_port_arbiter_fsm #(
    parameter int unsigned MAX_LOCK = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic [1:0] lock_i,
    input  logic       hold_i,
    output logic [1:0] gnt_o
);
    localparam int unsigned CNT_W = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LOCK - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOCK0,
        LOCK1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             owner;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // Grants never depend on hold_i, which is derived from them at the top level.
    always_comb begin
        gnt_o = '0;
        unique case (state_q)
            IDLE:    gnt_o = (req_i == 2'b11) ? (last_q ? 2'b01 : 2'b10) : req_i;
            LOCK0:   gnt_o = {1'b0, req_i[0]};
            LOCK1:   gnt_o = {req_i[1], 1'b0};
            default: gnt_o = '0;
        endcase
        if (!rst_ni) begin
            gnt_o = '0;
        end
    end

    assign owner = (state_q == LOCK1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        if (!hold_i) begin
            unique case (state_q)
                IDLE: begin
                    if (gnt_o != '0) begin
                        last_d = gnt_o[1];
                        if (lock_i[gnt_o[1]]) begin
                            state_d = gnt_o[1] ? LOCK1 : LOCK0;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                LOCK0, LOCK1: begin
                    if (!lock_i[owner] || cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

module sram_port_arbiter #(
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned MAX_LOCK = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [1:0]        wr_req_i,
    input  logic [1:0]        wr_lock_i,
    input  logic [ADDR_W-1:0] wr_addr_i [2],
    input  logic [DATA_W-1:0] wr_data_i [2],
    output logic [1:0]        wr_gnt_o,
    input  logic [1:0]        rd_req_i,
    input  logic [1:0]        rd_lock_i,
    input  logic [ADDR_W-1:0] rd_addr_i [2],
    output logic [1:0]        rd_gnt_o,
    output logic [1:0]        rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_w_addr_o,
    output logic [DATA_W-1:0] mem_w_data_o,
    output logic              mem_read_o,
    output logic [ADDR_W-1:0] mem_r_addr_o,
    input  logic [DATA_W-1:0] mem_r_data_i
);
    logic [1:0]        rd_cand;
    logic [ADDR_W-1:0] rd_cand_addr;
    logic              collide;
    logic              rd_pend;
    logic              rd_tag;

    sram_port_arbiter_fsm #(.MAX_LOCK(MAX_LOCK)) u_wr_fsm (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (wr_req_i),
        .lock_i (wr_lock_i),
        .hold_i (1'b0),
        .gnt_o  (wr_gnt_o)
    );

    sram_port_arbiter_fsm #(.MAX_LOCK(MAX_LOCK)) u_rd_fsm (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (rd_req_i),
        .lock_i (rd_lock_i),
        .hold_i (collide),
        .gnt_o  (rd_cand)
    );

    always_comb begin
        mem_w_addr_o = '0;
        mem_w_data_o = '0;
        if (wr_gnt_o[0]) begin
            mem_w_addr_o = wr_addr_i[0];
            mem_w_data_o = wr_data_i[0];
        end else if (wr_gnt_o[1]) begin
            mem_w_addr_o = wr_addr_i[1];
            mem_w_data_o = wr_data_i[1];
        end
    end

    always_comb begin
        rd_cand_addr = '0;
        if (rd_cand[0]) begin
            rd_cand_addr = rd_addr_i[0];
        end else if (rd_cand[1]) begin
            rd_cand_addr = rd_addr_i[1];
        end
    end

    // Same-address read and write in one cycle: the write wins, the read retries.
    assign collide      = (|wr_gnt_o) && (|rd_cand) && (mem_w_addr_o == rd_cand_addr);
    assign rd_gnt_o     = collide ? 2'b00 : rd_cand;
    assign mem_write_o  = |wr_gnt_o;
    assign mem_read_o   = |rd_gnt_o;
    assign mem_r_addr_o = collide ? '0 : rd_cand_addr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_pend <= 1'b0;
            rd_tag  <= 1'b0;
        end else begin
            rd_pend <= |rd_gnt_o;
            if (|rd_gnt_o) begin
                rd_tag <= rd_gnt_o[1];
            end
        end
    end

    assign rd_valid_o = rd_pend ? (rd_tag ? 2'b10 : 2'b01) : 2'b00;
    assign rd_data_o  = mem_r_data_i;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural arbitration and memory model.

module tb_sram_port_arbiter;
    localparam int AW = 9;
    localparam int DW = 64;
    localparam int ML = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    wr_req, wr_lock, rd_req, rd_lock;
    logic [AW-1:0] wr_addr [2];
    logic [DW-1:0] wr_data [2];
    logic [AW-1:0] rd_addr [2];
    logic [1:0]    wr_gnt, rd_gnt, rd_valid;
    logic [DW-1:0] rd_data;
    logic          mem_write, mem_read;
    logic [AW-1:0] mem_w_addr, mem_r_addr;
    logic [DW-1:0] mem_w_data;
    logic [DW-1:0] mem_r_data = '0;
    logic [DW-1:0] sram [512];

    int checks = 0;
    int failures = 0;

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .wr_req_i     (wr_req),
        .wr_lock_i    (wr_lock),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .wr_gnt_o     (wr_gnt),
        .rd_req_i     (rd_req),
        .rd_lock_i    (rd_lock),
        .rd_addr_i    (rd_addr),
        .rd_gnt_o     (rd_gnt),
        .rd_valid_o   (rd_valid),
        .rd_data_o    (rd_data),
        .mem_write_o  (mem_write),
        .mem_w_addr_o (mem_w_addr),
        .mem_w_data_o (mem_w_data),
        .mem_read_o   (mem_read),
        .mem_r_addr_o (mem_r_addr),
        .mem_r_data_i (mem_r_data)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int a);
        return 64'hC0DE_0000_5A00_0000 | DW'(a);
    endfunction

    // Environment SRAM: one write port, one read port with a registered output.
    always @(posedge clk) begin
        if (mem_read) mem_r_data <= sram[mem_r_addr];
        if (mem_write) sram[mem_w_addr] <= mem_w_data;
    end

    // Reference model: which requester wins, given who holds a lock and who went last.
    function automatic int pick(input int hold, input int last, input logic [1:0] req);
        if (hold >= 0) return req[hold] ? hold : -1;
        if (req == 2'b11) return 1 - last;
        if (req[0]) return 0;
        if (req[1]) return 1;
        return -1;
    endfunction

    task automatic advance(inout int hold, inout int held, inout int last,
                           input int g, input logic [1:0] lk);
        if (hold < 0) begin
            if (g >= 0) begin
                last = g;
                if (lk[g]) begin
                    hold = g;
                    held = 1;
                end
            end
        end else begin
            held++;
            if (!lk[hold] || held >= ML) hold = -1;
        end
    endtask

    task automatic clear_inputs();
        wr_req = '0; wr_lock = '0; rd_req = '0; rd_lock = '0;
        for (int i = 0; i < 2; i++) begin
            wr_addr[i] = '0; wr_data[i] = '0; rd_addr[i] = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wr_req = 2'b11; rd_req = 2'b11;
        wr_addr[0] = 9'h001; wr_addr[1] = 9'h002;
        rd_addr[0] = 9'h003; rd_addr[1] = 9'h004;
        wr_data[0] = 64'h1111; wr_data[1] = 64'h2222;
        #1;
        checks++;
        if ({wr_gnt, rd_gnt, mem_write, mem_read, rd_valid} !== 8'b0) begin
            failures++;
            $display("FAIL reset_grants: got wr=%b rd=%b mw=%b mr=%b v=%b, want all 0",
                     wr_gnt, rd_gnt, mem_write, mem_read, rd_valid);
        end
        wr_req = '0; rd_req = '0;
        #1;
        checks++;
        if (mem_w_addr !== '0 || mem_r_addr !== '0 || mem_w_data !== '0) begin
            failures++;
            $display("FAIL reset_mux: got wa=%0h ra=%0h wd=%0h, want 0", mem_w_addr, mem_r_addr, mem_w_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wr_req = 2'b11; rd_req = 2'b11;
        #1;
        checks++;
        if (wr_gnt !== 2'b01 || rd_gnt !== 2'b01) begin
            failures++;
            $display("FAIL reset_cycle0: got wr=%b rd=%b, want 01 01", wr_gnt, rd_gnt);
        end
        @(negedge clk);
        #1;
        checks++;
        if (wr_gnt !== 2'b10 || rd_gnt !== 2'b10 || rd_valid !== 2'b01) begin
            failures++;
            $display("FAIL reset_cycle1: got wr=%b rd=%b v=%b, want 10 10 01", wr_gnt, rd_gnt, rd_valid);
        end
        checks++;
        if (rd_data !== init_word(3)) begin
            failures++;
            $display("FAIL reset_rdata: got %0h want %0h", rd_data, init_word(3));
        end
        clear_inputs();
    endtask

    task automatic test_alternate();
        int own;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            wr_req = 2'b11;
            wr_addr[0] = AW'(9'h020 + k); wr_addr[1] = AW'(9'h030 + k);
            wr_data[0] = DW'(k); wr_data[1] = DW'(100 + k);
            #1;
            own = k % 2;
            checks++;
            if (wr_gnt !== 2'(1 << own)) begin
                failures++;
                $display("FAIL alt_gnt[%0d]: got %b want owner %0d", k, wr_gnt, own);
            end
            checks++;
            if (mem_w_addr !== AW'((own != 0 ? 9'h030 : 9'h020) + k)) begin
                failures++;
                $display("FAIL alt_addr[%0d]: got %0h want owner %0d addr", k, mem_w_addr, own);
            end
        end
        clear_inputs();
    endtask

    task automatic test_write_lock();
        logic [1:0] exp;
        do_reset();
        @(negedge clk);
        wr_req = 2'b01; wr_addr[0] = 9'h050;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            wr_req = {k < 4, 1'b1};
            wr_lock = {k < 3, 1'b0};
            wr_addr[0] = 9'h050;
            wr_addr[1] = AW'(9'h010 + k);
            wr_data[1] = DW'(64'hAB00 + k);
            #1;
            exp = (k < 4) ? 2'b10 : 2'b01;
            checks++;
            if (wr_gnt !== exp || (k < 4 && mem_w_addr !== AW'(9'h010 + k))) begin
                failures++;
                $display("FAIL wlock[%0d]: got gnt=%b addr=%0h want gnt=%b", k, wr_gnt, mem_w_addr, exp);
            end
        end
        clear_inputs();
    endtask

    task automatic test_read_lock();
        int r0_grants = 0;
        do_reset();
        for (int k = 0; k <= ML; k++) begin
            @(negedge clk);
            rd_req = 2'b11; rd_lock = 2'b01;
            rd_addr[0] = 9'h060; rd_addr[1] = 9'h061;
            #1;
            if (rd_gnt == 2'b01) r0_grants++;
            checks++;
            if (rd_gnt !== ((k < ML) ? 2'b01 : 2'b10)) begin
                failures++;
                $display("FAIL rlock_gnt[%0d]: got %b want %b", k, rd_gnt, (k < ML) ? 2'b01 : 2'b10);
            end
            checks++;
            if (rd_valid !== ((k == 0) ? 2'b00 : 2'b01)) begin
                failures++;
                $display("FAIL rlock_valid[%0d]: got %b", k, rd_valid);
            end
        end
        checks++;
        if (r0_grants != ML) begin
            failures++;
            $display("FAIL rlock_count: got %0d want %0d", r0_grants, ML);
        end
        clear_inputs();
    endtask

    task automatic test_collision();
        logic [DW-1:0] d = 64'hDEAD_BEEF_0123_4567;
        do_reset();
        @(negedge clk);
        wr_req = 2'b01; wr_addr[0] = 9'h02A; wr_data[0] = d;
        rd_req = 2'b10; rd_addr[1] = 9'h02A;
        #1;
        checks++;
        if (wr_gnt !== 2'b01 || rd_gnt !== 2'b00 || mem_read !== 1'b0) begin
            failures++;
            $display("FAIL coll_block: got wr=%b rd=%b mr=%b want 01 00 0", wr_gnt, rd_gnt, mem_read);
        end
        @(negedge clk);
        wr_req = 2'b00;
        #1;
        checks++;
        if (rd_gnt !== 2'b10 || mem_r_addr !== 9'h02A) begin
            failures++;
            $display("FAIL coll_retry: got rd=%b ra=%0h want 10 2a", rd_gnt, mem_r_addr);
        end
        @(negedge clk);
        rd_req = 2'b00;
        #1;
        checks++;
        if (rd_valid !== 2'b10 || rd_data !== d) begin
            failures++;
            $display("FAIL coll_data: got v=%b d=%0h want 10 %0h", rd_valid, rd_data, d);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        @(negedge clk);
        rd_req = 2'b01; rd_addr[0] = 9'h070;
        @(negedge clk);
        rd_req = 2'b11; rd_lock = 2'b10; rd_addr[1] = 9'h071;
        #1;
        checks++;
        if (rd_gnt !== 2'b10) begin
            failures++;
            $display("FAIL midlock_enter: got %b want 10", rd_gnt);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rd_gnt !== 2'b10 || rd_valid !== 2'b10) begin
            failures++;
            $display("FAIL midlock_hold: got gnt=%b v=%b want 10 10", rd_gnt, rd_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (rd_gnt !== 2'b00 || wr_gnt !== 2'b00 || rd_valid !== 2'b00) begin
            failures++;
            $display("FAIL midlock_reset: got rd=%b wr=%b v=%b want 0", rd_gnt, wr_gnt, rd_valid);
        end
        @(negedge clk);
        rst_n = 1'b1; rd_lock = 2'b00;
        #1;
        checks++;
        if (rd_gnt !== 2'b01 || rd_valid !== 2'b00) begin
            failures++;
            $display("FAIL midlock_after: got gnt=%b v=%b want 01 00", rd_gnt, rd_valid);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        int w_hold = -1, w_held = 0, w_last = 1;
        int r_hold = -1, r_held = 0, r_last = 1;
        int pend = -1;
        int wg, rc, rg;
        bit sup;
        logic [DW-1:0] pend_data = '0;
        logic [DW-1:0] ref_mem [512];
        logic [AW-1:0] e_wa, e_ra;
        logic [DW-1:0] e_wd;
        for (int a = 0; a < 512; a++) ref_mem[a] = init_word(a);
        do_reset();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                wr_req[i] = ($urandom_range(0, 3) != 0);
                rd_req[i] = ($urandom_range(0, 3) != 0);
                wr_lock[i] = ($urandom_range(0, 5) != 0);
                rd_lock[i] = ($urandom_range(0, 5) != 0);
                wr_addr[i] = AW'(9'h100 + $urandom_range(0, 5));
                rd_addr[i] = AW'(9'h100 + $urandom_range(0, 5));
                wr_data[i] = {$urandom, $urandom};
            end
            #1;
            wg = pick(w_hold, w_last, wr_req);
            rc = pick(r_hold, r_last, rd_req);
            sup = (wg >= 0) && (rc >= 0) && (wr_addr[wg] == rd_addr[rc]);
            rg = sup ? -1 : rc;
            e_wa = (wg >= 0) ? wr_addr[wg] : '0;
            e_wd = (wg >= 0) ? wr_data[wg] : '0;
            e_ra = (rg >= 0) ? rd_addr[rg] : '0;
            checks++;
            if (wr_gnt !== ((wg >= 0) ? 2'(1 << wg) : 2'b00) || mem_write !== (wg >= 0)) begin
                failures++;
                $display("FAIL rnd_wgnt[%0d]: got %b want owner %0d", n, wr_gnt, wg);
            end
            checks++;
            if (rd_gnt !== ((rg >= 0) ? 2'(1 << rg) : 2'b00) || mem_read !== (rg >= 0)) begin
                failures++;
                $display("FAIL rnd_rgnt[%0d]: got %b want owner %0d", n, rd_gnt, rg);
            end
            checks++;
            if (mem_w_addr !== e_wa || mem_w_data !== e_wd || mem_r_addr !== e_ra) begin
                failures++;
                $display("FAIL rnd_mux[%0d]: got wa=%0h wd=%0h ra=%0h want %0h %0h %0h",
                         n, mem_w_addr, mem_w_data, mem_r_addr, e_wa, e_wd, e_ra);
            end
            checks++;
            if (rd_valid !== ((pend >= 0) ? 2'(1 << pend) : 2'b00)) begin
                failures++;
                $display("FAIL rnd_valid[%0d]: got %b want owner %0d", n, rd_valid, pend);
            end
            if (pend >= 0) begin
                checks++;
                if (rd_data !== pend_data) begin
                    failures++;
                    $display("FAIL rnd_rdata[%0d]: got %0h want %0h", n, rd_data, pend_data);
                end
            end
            advance(w_hold, w_held, w_last, wg, wr_lock);
            if (!sup) advance(r_hold, r_held, r_last, rc, rd_lock);
            pend = rg;
            if (rg >= 0) pend_data = ref_mem[rd_addr[rg]];
            if (wg >= 0) ref_mem[wr_addr[wg]] = wr_data[wg];
        end
        clear_inputs();
    endtask

    initial begin
        for (int a = 0; a < 512; a++) sram[a] = init_word(a);
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_alternate();
        test_write_lock();
        test_read_lock();
        test_collision();
        test_reset_mid_lock();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-requester arbiter for the calculator's 64-bit memory, which is built from two 32-bit SRAM macros sharing one address. The calculator controller (requester 0) and a host/debug loader (requester 1) share the memory through this block. The write port (SRAM port 0) and the read port (SRAM port 1) are arbitrated independently with round-robin priority. Each port supports a bounded lock for bursts and blocks same-address read/write collisions.

## Interface
- ADDR_W, 9, memory word address width
- DATA_W, 64, memory word width (MEM_WORD_SIZE)
- MAX_LOCK, 16, maximum consecutive cycles one requester may hold a locked port (≥2)

- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- wr_req_i[r]  in  1  write request, r∈{0,1}
- wr_lock_i[r]  in  1  keep write port after this grant
- wr_addr_i[r]  in  ADDR_W  write address
- wr_data_i[r]  in  DATA_W  write data
- wr_gnt_o[r]  out  1  write accepted this cycle
- rd_req_i[r]  in  1  read request
- rd_lock_i[r]  in  1  keep read port after this grant
- rd_addr_i[r]  in  ADDR_W  read address
- rd_gnt_o[r]  out  1  read accepted this cycle
- rd_valid_o[r]  out  1  rd_data_o valid for requester r
- rd_data_o  out  DATA_W  read data, shared by both requesters
- mem_write_o  out  1  SRAM port-0 write strobe (active-high; top inverts to csb0/web0)
- mem_w_addr_o  out  ADDR_W  SRAM write address
- mem_w_data_o  out  DATA_W  SRAM write data, [31:0] to macro A, [63:32] to macro B
- mem_read_o  out  1  SRAM port-1 read strobe (active-high)
- mem_r_addr_o  out  ADDR_W  SRAM read address
- mem_r_data_i  in  DATA_W  SRAM read data, valid the cycle after mem_read_o

## Operation
- The write port and the read port each run an identical FSM: IDLE, LOCK0, LOCK1.
- IDLE:
  - Grant the single requester if only one requests.
  - If both request, grant the requester not pointed to by last_owner.
  - When the grant goes to r with lock_i[r]=0, set last_owner=r.
  - When the grant goes to r with lock_i[r]=1, go to LOCKr, set lock_cnt=1 and last_owner=r.
- LOCKr:
  - Only r may be granted, whenever req_i[r]=1. The other requester is stalled, even while r is idle.
  - Exit to IDLE at the end of any cycle with lock_i[r]=0. The grant in that cycle is still honoured.
  - Otherwise lock_cnt increments each cycle. At lock_cnt==MAX_LOCK, go to IDLE (forced release).
  - After a forced release, r is lowest priority in the next IDLE cycle.
- Grants are combinational on the current state and requests. A grant means the transfer happens this cycle; there is no back-pressure after a grant.
- mem_write_o = OR of wr_gnt_o. Write address and data are muxed from the granted requester, and are 0 when there is no grant.
- mem_read_o and mem_r_addr_o are muxed the same way from the read grant.
- Collision rule: if both ports would grant in the same cycle with equal addresses, the read grant is suppressed for that cycle. The write proceeds. Read-port FSM state and last_owner do not change on a suppressed cycle.
- Read return:
  - The granted owner is registered into rd_tag.
  - rd_valid_o[rd_tag] is high the cycle after rd_gnt_o.
  - rd_data_o = mem_r_data_i unconditionally.
- Back-to-back reads are allowed every cycle; rd_valid_o tracks each grant one cycle later.

## Timing
- Reset values: FSMs=IDLE, last_owner=1 (requester 0 wins the first tie), lock_cnt=0, rd_valid_o=0.
- With no requests in reset, all grants and mem strobes are 0, and all muxed address/data outputs are 0.
- Grant latency is 0 cycles. Read data latency is 1 cycle after grant.
- Reset mid-lock: the FSM returns to IDLE asynchronously and rd_valid_o clears. An in-flight read return is dropped.
- lock_i is sampled only in a granted cycle (entry to LOCK) or in LOCKr (hold or exit).

## Test plan
- Reset with all requests high, then release at cycle 0. Cycle 0 → wr_gnt_o[0]=1, rd_gnt_o[0]=1. Cycle 1 → both grants go to requester 1, and rd_valid_o[0]=1 with rd_data_o = mem_r_data_i.
- Continuous write requests from both, no lock, 6 cycles → wr_gnt_o owner alternates 0,1,0,1,0,1. The mem_w_addr_o sequence matches each requester's addresses.
- Requester 1 writes addresses 0x10–0x13 with wr_lock high for the first 3 grants while requester 0 requests throughout → 4 consecutive grants to requester 1, then requester 0 is granted in cycle 5.
- Requester 0 holds rd_lock=1 and rd_req=1 indefinitely with MAX_LOCK=16 while requester 1 requests → 16 grants to requester 0, then requester 1 is granted on cycle 17.
- Same cycle write 0x2A (requester 0) and read 0x2A (requester 1) → wr_gnt_o[0]=1, rd_gnt_o[1]=0. Next cycle rd_gnt_o[1]=1, and rd_valid_o[1] the cycle after returns the written data.
- Assert rst_ni low during LOCK1 with a read in flight → grants=0 and rd_valid_o=0 immediately. After release, a tie goes to requester 0.
